// File: rtl/floor_stepper_if.sv
// Request handshake between the scheduler and the floor stepper.
interface floor_stepper_if;
  logic       req_valid;
  logic [2:0] req_floor;
  logic       req_ready;

  modport master (output req_valid, output req_floor, input req_ready);
  modport slave  (input req_valid, input req_floor, output req_ready);
endinterface

// File: rtl/floor_stepper.sv
// Elevator car position generator: accepts a target floor, steps the car one
// floor per TICKS_PER_FLOOR cycles, holds the door open for DOOR_TICKS cycles,
// and drives a 7-bit thermometer floor vector for the floor-number display.
module floor_stepper #(
  parameter int TOP_FLOOR       = 6,
  parameter int TICKS_PER_FLOOR = 50,
  parameter int DOOR_TICKS      = 100
) (
  input  logic              clk,
  input  logic              reset_n,
  floor_stepper_if.slave    req,
  output logic [6:0]        floor,
  output logic              moving_up,
  output logic              moving_down,
  output logic              door_open,
  output logic              arrived
);

  localparam int CNT_MAX = (TICKS_PER_FLOOR > DOOR_TICKS) ? TICKS_PER_FLOOR : DOOR_TICKS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [2:0]       TOP_F     = 3'(TOP_FLOOR);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(TICKS_PER_FLOOR - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST = CNT_W'(DOOR_TICKS - 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [6:0]       floor_nx;
  logic [2:0]       target, target_nx;
  logic             arrived_nx;
  logic [2:0]       cur;
  logic [2:0]       req_clamped;

  // Floor index of a thermometer code is simply its number of set bits.
  function automatic logic [2:0] popcount(input logic [6:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 7; i++) n = n + 3'(v[i]);
    return n;
  endfunction

  // Requests above the top floor are served as the top floor.
  function automatic logic [2:0] clamp_floor(input logic [2:0] f);
    return (f > TOP_F) ? TOP_F : f;
  endfunction

  assign cur         = popcount(floor);
  assign req_clamped = clamp_floor(req.req_floor);

  // Next-state logic: request accept, per-floor stepping, arrival and door dwell.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    floor_nx   = floor;
    target_nx  = target;
    arrived_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (req.req_valid) begin
          target_nx = req_clamped;
          cnt_nx    = '0;
          if (req_clamped > cur) begin
            state_nx = MOVE_UP;
          end else if (req_clamped < cur) begin
            state_nx = MOVE_DOWN;
          end else begin
            state_nx   = DOOR;
            arrived_nx = 1'b1;
          end
        end
      end
      MOVE_UP: begin
        if (cnt == STEP_LAST) begin
          cnt_nx = '0;
          // Top-floor guard keeps the code inside the shaft even if target were corrupt.
          if (cur < TOP_F) floor_nx = {floor[5:0], 1'b1};
          if (cur + 3'd1 >= target || cur >= TOP_F) begin
            state_nx   = DOOR;
            arrived_nx = 1'b1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      MOVE_DOWN: begin
        if (cnt == STEP_LAST) begin
          cnt_nx = '0;
          if (cur != 3'd0) floor_nx = {1'b0, floor[6:1]};
          if (cur <= target + 3'd1) begin
            state_nx   = DOOR;
            arrived_nx = 1'b1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DOOR: begin
        if (cnt == DOOR_LAST) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // State register; reset abandons any trip and returns the car to floor 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      floor   <= '0;
      target  <= '0;
      arrived <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      floor   <= floor_nx;
      target  <= target_nx;
      arrived <= arrived_nx;
    end
  end

  assign req.req_ready = (state == IDLE);
  assign moving_up     = (state == MOVE_UP);
  assign moving_down   = (state == MOVE_DOWN);
  assign door_open     = (state == DOOR);

endmodule

// File: tb/tb_floor_stepper.sv
// Bench for floor_stepper: directed trips plus random requests and resets,
// checked every cycle against a trip-timeline reference model.
module tb_floor_stepper;

  localparam int T   = 4;
  localparam int D   = 3;
  localparam int TOP = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] floor;
  logic       moving_up, moving_down, door_open, arrived;

  floor_stepper_if req_if ();

  floor_stepper #(
    .TOP_FLOOR(TOP),
    .TICKS_PER_FLOOR(T),
    .DOOR_TICKS(D)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(req_if.slave),
    .floor(floor),
    .moving_up(moving_up),
    .moving_down(moving_down),
    .door_open(door_open),
    .arrived(arrived)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [11:0] exp_q[$];
  int          pos = 0;
  logic        accepted = 1'b0;

  task automatic check_eq(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %03h expected %03h (ready,up,down,door,arrived,floor)", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] therm(input int n);
    logic [6:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [11:0] observed();
    return {req_if.req_ready, moving_up, moving_down, door_open, arrived, floor};
  endfunction

  function automatic logic [11:0] expected();
    if (exp_q.size() == 0) return {1'b1, 4'b0000, therm(pos)};
    return exp_q[0];
  endfunction

  // Whole-trip timeline: entry i is the visible state i edges after the accept edge.
  task automatic plan_trip(input int c, input int t);
    int  d;
    bit  up;
    int  f;
    up = (t > c);
    d  = up ? (t - c) : (c - t);
    for (int i = 0; i < d * T + D; i++) begin
      if (i < d * T) begin
        f = up ? (c + i / T) : (c - i / T);
        exp_q.push_back({1'b0, up, ~up, 1'b0, 1'b0, therm(f)});
      end else begin
        exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, (i == d * T), therm(t)});
      end
    end
  endtask

  task automatic do_cycle(input logic v, input logic [2:0] f);
    int t;
    @(negedge clk);
    check_eq("outputs", observed(), expected());
    req_if.req_valid = v;
    req_if.req_floor = f;
    @(posedge clk);
    #1;
    accepted = 1'b0;
    if (exp_q.size() == 0) begin
      if (v) begin
        t = (int'(f) > TOP) ? TOP : int'(f);
        plan_trip(pos, t);
        pos = t;
        accepted = 1'b1;
      end
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_if.req_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_eq("async_reset", observed(), {1'b1, 11'b0});
    exp_q.delete();
    pos = 0;
    @(posedge clk);
    #1 check_eq("reset_hold", observed(), {1'b1, 11'b0});
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  int list[5] = '{3, 1, 1, 7, 2};

  initial begin
    req_if.req_valid = 1'b0;
    req_if.req_floor = 3'd0;
    repeat (2) @(posedge clk);
    #1 check_eq("reset_state", observed(), {1'b1, 11'b0});
    @(negedge clk);
    reset_n = 1'b1;

    // Directed trips; while moving, a competing request for floor 0 is held.
    for (int k = 0; k < 5; k++) begin
      int w;
      w = 0;
      accepted = 1'b0;
      while (!accepted && w < 50) begin
        do_cycle(1'b1, 3'(list[k]));
        w++;
      end
      check_eq("accept", {11'b0, accepted}, 12'd1);
      if (k == 4) begin
        repeat (9) do_cycle(1'b1, 3'd0);
        do_reset();
      end else begin
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
          do_cycle(1'b1, 3'd0);
          w++;
        end
        check_eq("trip_done", {11'b0, req_if.req_ready}, 12'd1);
      end
    end

    // Random requests (including out-of-range floors) and occasional resets.
    repeat (2500) begin
      if ($urandom % 300 == 0) do_reset();
      else do_cycle(($urandom % 4) == 0, 3'($urandom % 8));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
